mem_responder: RTL



---
 rtl/mem_map_pkg.sv | 16 +
 rtl/mem_responder_byte_fifo.sv | 60 ++++++
 rtl/mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// Address map of the responder's IO window and the decode helper shared by
// the top level and the bench.
package mem_map_pkg;

   localparam logic [17:0] IO_BASE   = 18'h30000;
   localparam logic [17:0] IO_DATA   = 18'h30000;
   localparam logic [17:0] IO_STATUS = 18'h30004;

   localparam int IO_SEL_HI = 17;
   localparam int IO_SEL_LO = 16;

   function automatic logic is_io(input logic [17:0] addr);
      return addr[IO_SEL_HI:IO_SEL_LO] == IO_BASE[IO_SEL_HI:IO_SEL_LO];
   endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// Byte FIFO with occupancy count; dout shows the head combinationally so the
// bus-side read can capture it in the same cycle it pops.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   push,
   input  logic                   pop,
   input  logic [7:0]             din,
   output logic [7:0]             dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    buf_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = buf_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk_in) begin
      if (do_push) begin
         buf_q[wr_ptr_q] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Far-end bus responder: byte RAM plus a UART/control window at 0x30000 with
// TX and RX byte FIFOs toward the host link.
module mem_responder
   import mem_map_pkg::*;
#(
   parameter int    ADDR_WIDTH  = 17,
   parameter string INIT_FILE   = "",
   parameter int    TX_DEPTH    = 16,
   parameter int    RX_DEPTH    = 16,
   parameter int    FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        halt,
   output logic        tx_overflow
);

   localparam int TX_CW = $clog2(TX_DEPTH) + 1;
   localparam int RX_CW = $clog2(RX_DEPTH) + 1;
   localparam logic [TX_CW-1:0] TX_THRESH = TX_CW'(TX_DEPTH - FULL_MARGIN);

   logic [7:0]            mem_q [2**ADDR_WIDTH];
   logic [7:0]            ram_rd_q;
   logic [7:0]            io_rd_q;
   logic [7:0]            io_rd_d;
   logic                  rd_from_io_q;
   logic                  halt_q;
   logic                  tx_overflow_q;

   logic [17:0]           addr;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  io_sel;
   logic                  bus_rd;
   logic                  bus_wr;
   logic                  hit_data;
   logic                  hit_status;
   logic                  unused_addr_hi;

   logic                  tx_push;
   logic                  tx_pop;
   logic                  tx_drop;
   logic                  tx_full;
   logic                  tx_empty;
   logic [TX_CW-1:0]      tx_count;
   logic                  rx_push;
   logic                  rx_pop;
   logic                  rx_full;
   logic                  rx_empty;
   logic [7:0]            rx_head;
   logic [RX_CW-1:0]      unused_rx_count;

   assign addr           = mem_a[17:0];
   assign idx            = mem_a[ADDR_WIDTH-1:0];
   assign unused_addr_hi = ^mem_a[31:18];
   assign io_sel         = is_io(addr);
   assign bus_rd         = rdy_in && !mem_wr;
   assign bus_wr         = rdy_in && mem_wr;
   assign hit_data       = io_sel && (addr == IO_DATA);
   assign hit_status     = io_sel && (addr == IO_STATUS);

   assign tx_push  = bus_wr && hit_data && !tx_full;
   assign tx_drop  = bus_wr && hit_data && tx_full;
   assign tx_valid = rdy_in && !tx_empty;
   assign tx_pop   = tx_valid && tx_ready;
   assign rx_ready = rdy_in && !rx_full;
   assign rx_push  = rx_valid && rx_ready;
   assign rx_pop   = bus_rd && hit_data && !rx_empty;

   assign io_buffer_full = (tx_count >= TX_THRESH);
   assign halt           = halt_q;
   assign tx_overflow    = tx_overflow_q;
   assign mem_din        = rd_from_io_q ? io_rd_q : ram_rd_q;

   // RAM stays out of reset so it maps onto block RAM with a registered read.
   always_ff @(posedge clk_in) begin
      if (bus_wr && !io_sel) begin
         mem_q[idx] <= mem_dout;
      end
      if (bus_rd && !io_sel) begin
         ram_rd_q <= mem_q[idx];
      end
   end

   always_comb begin
      io_rd_d = 8'h00;
      if (hit_data && !rx_empty) begin
         io_rd_d = rx_head;
      end else if (hit_status) begin
         io_rd_d = {6'b0, !rx_empty, tx_full};
      end
   end

   // Reset points the output mux at the cleared IO register so mem_din reads 0.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         io_rd_q       <= 8'h00;
         rd_from_io_q  <= 1'b1;
         halt_q        <= 1'b0;
         tx_overflow_q <= 1'b0;
      end else begin
         if (bus_rd) begin
            rd_from_io_q <= io_sel;
            if (io_sel) begin
               io_rd_q <= io_rd_d;
            end
         end
         if (bus_wr && hit_status) begin
            halt_q <= 1'b1;
         end
         if (tx_drop) begin
            tx_overflow_q <= 1'b1;
         end
      end
   end

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .push     (tx_push),
      .pop      (tx_pop),
      .din      (mem_dout),
      .dout     (tx_data),
      .count    (tx_count),
      .full     (tx_full),
      .empty    (tx_empty)
   );

   byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .push     (rx_push),
      .pop      (rx_pop),
      .din      (rx_data),
      .dout     (rx_head),
      .count    (unused_rx_count),
      .full     (rx_full),
      .empty    (rx_empty)
   );

endmodule
